// File: rtl/clkrst_pkg.sv
// Shared types and default configuration for the clock/reset controller.
// The controller FSM walks RST_HOLD -> POR_WAIT -> RUN after reset is released.
package clkrst_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    POR_WAIT = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam int DEF_DIV_RATIO       = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_POR_CYCLES      = 16;
  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_STEP_KEY        = 0;

  localparam int DIV_W = 16;

endpackage

// File: rtl/key_debounce.sv
// Per-key front end: 2-flop synchronizer, optional debounce filter, press pulse.
// Build macro CLKRST_DEBOUNCE_EN enables the debounce counter; without it the
// synchronized level is used directly.
// The synchronizer stores the inverted key so that a cleared flop means
// "not pressed", which keeps the level at 0 while reset is asserted.
module key_debounce
  import clkrst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic rstn_async,
  input  logic key_raw,
  output logic level,
  output logic press
);

  logic [1:0] sync_q;
  logic       synced;
  logic       level_d_q;
  logic       press_q;

  // Bring the raw active-low key into the clock domain as pressed = 1
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) sync_q <= '0;
    else             sync_q <= {sync_q[0], ~key_raw};
  end

  assign synced = sync_q[1];

`ifdef CLKRST_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (synced == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      db_q  <= synced;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = db_q;
`else
  // Without the filter the length setting has no effect; both arms are the
  // direct path from the synchronizer.
  if (DEBOUNCE_CYCLES > 0) begin : g_direct
    assign level = synced;
  end else begin : g_direct_zero
    assign level = synced;
  end
`endif

  // Register a one-cycle pulse the cycle after the level rises
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) begin
      level_d_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      level_d_q <= level;
      press_q   <= level & ~level_d_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Board-level clock-enable and reset controller.
// Releases the core reset through a synchronizer plus a power-on hold, then
// produces a core clock enable either from a free-running divider or, in
// single-step mode, from presses of STEP_KEY.
// Build macro CLKRST_DEBOUNCE_EN enables key debouncing in key_debounce.
module clk_rst_ctrl
  import clkrst_pkg::*;
#(
  parameter int DIV_RATIO       = DEF_DIV_RATIO,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int POR_CYCLES      = DEF_POR_CYCLES,
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STEP_KEY        = DEF_STEP_KEY
) (
  input  logic                CLOCK_50,
  input  logic                rstn_async,
  input  logic [NUM_KEYS-1:0] i_key,
  input  logic                i_step_mode,
  output logic                o_rstn,
  output logic                o_ce,
  output logic [NUM_KEYS-1:0] o_key_db,
  output logic [NUM_KEYS-1:0] o_key_press,
  output logic                o_step_active
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic [16:0]      POR_LAST = 17'(POR_CYCLES) - 17'd1;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_released;

  state_t                 state_q;
  state_t                 state_d;
  logic [15:0]            por_cnt_q;
  logic [15:0]            por_cnt_d;
  logic                   rstn_q;

  logic [1:0]             step_sync_q;
  logic                   step_prev_q;
  logic                   step_active;
  logic                   step_change;

  logic [DIV_W-1:0]       div_cnt_q;
  logic [DIV_W-1:0]       div_cnt_d;
  logic                   ce_d;

  logic [NUM_KEYS-1:0]    key_db;
  logic [NUM_KEYS-1:0]    key_press;

  // Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES edges
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) rst_sync_q <= '0;
    else             rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_released = rst_sync_q[SYNC_STAGES-1];

  // Release sequencing: wait for the synchronizer, then hold POR_CYCLES more cycles
  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    case (state_q)
      RST_HOLD: begin
        por_cnt_d = '0;
        if (rst_released) state_d = (POR_CYCLES == 0) ? RUN : POR_WAIT;
      end
      POR_WAIT: begin
        if ({1'b0, por_cnt_q} == POR_LAST) state_d = RUN;
        else                               por_cnt_d = por_cnt_q + 16'd1;
      end
      RUN:      state_d = RUN;
      default:  state_d = RST_HOLD;
    endcase
  end

  // State, hold counter and the registered core reset
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q   <= RST_HOLD;
      por_cnt_q <= '0;
      rstn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      por_cnt_q <= por_cnt_d;
      rstn_q    <= (state_d == RUN);
    end
  end

  // Synchronize the step switch and remember its previous value to spot changes
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) begin
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[0], i_step_mode};
      step_prev_q <= step_sync_q[1];
    end
  end

  assign step_active = step_sync_q[1];
  assign step_change = step_active ^ step_prev_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .CLOCK_50  (CLOCK_50),
      .rstn_async(rstn_async),
      .key_raw   (i_key[k]),
      .level     (key_db[k]),
      .press     (key_press[k])
    );
  end

  // Clock-enable source: divider in free-run, step key in step mode; a mode
  // change restarts the divider and suppresses the enable for that cycle
  always_comb begin
    div_cnt_d = '0;
    ce_d      = 1'b0;
    if (state_q == RUN && !step_change) begin
      if (step_active) begin
        ce_d = key_press[STEP_KEY];
      end else begin
        ce_d      = (div_cnt_q == DIV_LAST);
        div_cnt_d = ce_d ? '0 : div_cnt_q + 1'b1;
      end
    end
  end

  // Divider counter register
  always_ff @(posedge CLOCK_50 or negedge rstn_async) begin
    if (!rstn_async) div_cnt_q <= '0;
    else             div_cnt_q <= div_cnt_d;
  end

  assign o_rstn        = rstn_q;
  assign o_ce          = ce_d;
  assign o_key_db      = key_db;
  assign o_key_press   = key_press;
  assign o_step_active = step_active;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Scoreboard bench for clk_rst_ctrl: two instances (divide by 2 and by 5)
// share the board inputs. Expected clock-enable pulses, key presses and core
// reset releases are queued by edge number when stimulus is driven and popped
// when the design produces them.
module tb_clk_rst_ctrl;

  localparam int DIV_A = 2;
  localparam int DIV_B = 5;
  localparam int DB    = 8;
`ifdef CLKRST_DEBOUNCE_EN
  localparam int DBLAT = 2 + DB;
  localparam int DBN   = DB;
`else
  localparam int DBLAT = 2;
  localparam int DBN   = 1;
`endif
  localparam int LAT   = DBLAT + 1;

  typedef struct packed {
    logic [31:0] at;
    logic [3:0]  mask;
  } press_t;

  logic       CLOCK_50;
  logic       rstn_async;
  logic [3:0] i_key;
  logic       i_step_mode;

  logic       rstnA, ceA, stepA, rstnB, ceB, stepB;
  logic [3:0] dbA, pressA, dbB, pressB;
  logic       prevRstnA = 1'b0;
  logic       prevRstnB = 1'b0;

  int         edgeNo = 0;
  int         vectorCount = 0;
  int         missCount = 0;

  int         ceQA[$];
  int         ceQB[$];
  int         rstnQA[$];
  int         rstnQB[$];
  press_t     pressQA[$];
  press_t     pressQB[$];

  clk_rst_ctrl #(
    .DIV_RATIO(DIV_A), .SYNC_STAGES(2), .POR_CYCLES(16), .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(DB), .STEP_KEY(0)
  ) dutA (
    .CLOCK_50(CLOCK_50), .rstn_async(rstn_async), .i_key(i_key),
    .i_step_mode(i_step_mode), .o_rstn(rstnA), .o_ce(ceA), .o_key_db(dbA),
    .o_key_press(pressA), .o_step_active(stepA)
  );

  clk_rst_ctrl #(
    .DIV_RATIO(DIV_B), .SYNC_STAGES(2), .POR_CYCLES(16), .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(DB), .STEP_KEY(0)
  ) dutB (
    .CLOCK_50(CLOCK_50), .rstn_async(rstn_async), .i_key(i_key),
    .i_step_mode(i_step_mode), .o_rstn(rstnB), .o_ce(ceB), .o_key_db(dbB),
    .o_key_press(pressB), .o_step_active(stepB)
  );

  // 50 MHz clock
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Count rising edges so every expectation can be stated as an edge number
  always @(posedge CLOCK_50) edgeNo <= edgeNo + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstnV, input logic [3:0] keyV, input logic stepV);
    rstn_async  = rstnV;
    i_key       = keyV;
    i_step_mode = stepV;
  endtask

  // Return 2 ns after the falling edge that follows rising edge e
  task automatic gotoEdge(input int e);
    forever begin
      @(negedge CLOCK_50);
      if (edgeNo >= e) break;
    end
    #2;
  endtask

  // Queue the free-running enable pulses of both instances whose divider
  // starts from 0 in the cycle after edge base, up to and including edge last
  task automatic pushFreeRun(input int base, input int last);
    for (int p = base + DIV_A - 1; p <= last; p += DIV_A) ceQA.push_back(p);
    for (int p = base + DIV_B - 1; p <= last; p += DIV_B) ceQB.push_back(p);
  endtask

  task automatic pushPress(input int at, input logic [3:0] mask);
    press_t e;
    e.at   = 32'(at);
    e.mask = mask;
    pressQA.push_back(e);
    pressQB.push_back(e);
  endtask

  // Monitor: pop the scoreboard whenever an instance produces an event
  always @(negedge CLOCK_50) begin
    press_t e;
    if (ceA === 1'b1) begin
      if (ceQA.size() > 0) checkOutput("ceA edge", 64'(edgeNo), 64'(ceQA.pop_front()));
      else                 checkOutput("ceA unexpected", 64'(edgeNo), '1);
    end
    if (ceB === 1'b1) begin
      if (ceQB.size() > 0) checkOutput("ceB edge", 64'(edgeNo), 64'(ceQB.pop_front()));
      else                 checkOutput("ceB unexpected", 64'(edgeNo), '1);
    end
    if (rstnA === 1'b1 && !prevRstnA) begin
      if (rstnQA.size() > 0) checkOutput("rstnA rise", 64'(edgeNo), 64'(rstnQA.pop_front()));
      else                   checkOutput("rstnA unexpected", 64'(edgeNo), '1);
    end
    if (rstnB === 1'b1 && !prevRstnB) begin
      if (rstnQB.size() > 0) checkOutput("rstnB rise", 64'(edgeNo), 64'(rstnQB.pop_front()));
      else                   checkOutput("rstnB unexpected", 64'(edgeNo), '1);
    end
    if ((|pressA) === 1'b1) begin
      if (pressQA.size() > 0) begin
        e = pressQA.pop_front();
        checkOutput("pressA", {32'(edgeNo), 28'd0, pressA}, {e.at, 28'd0, e.mask});
      end else checkOutput("pressA unexpected", {32'(edgeNo), 28'd0, pressA}, '1);
    end
    if ((|pressB) === 1'b1) begin
      if (pressQB.size() > 0) begin
        e = pressQB.pop_front();
        checkOutput("pressB", {32'(edgeNo), 28'd0, pressB}, {e.at, 28'd0, e.mask});
      end else checkOutput("pressB unexpected", {32'(edgeNo), 28'd0, pressB}, '1);
    end
    prevRstnA = (rstnA === 1'b1);
    prevRstnB = (rstnB === 1'b1);
  end

  initial begin
    int r, t, k, f, m, r2, fin, s;
    logic [3:0] keyV;
    int segLevel [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int segDur   [10] = '{3, 2, 3, 2, 20, 2, 3, 2, 3, 20};

    keyV = 4'hF;
    applyStimulus(1'b0, keyV, 1'b0);

    // Reset state, including inputs that are active while reset is held
    gotoEdge(3);
    checkOutput("reset A", {rstnA, ceA, stepA, dbA, pressA}, '0);
    checkOutput("reset B", {rstnB, ceB, stepB, dbB, pressB}, '0);
    applyStimulus(1'b0, 4'h0, 1'b1);
    gotoEdge(6);
    checkOutput("reset held A", {rstnA, ceA, stepA, dbA, pressA}, '0);
    checkOutput("reset held B", {rstnB, ceB, stepB, dbB, pressB}, '0);
    applyStimulus(1'b0, keyV, 1'b0);
    gotoEdge(8);

    // Reset release and free-running divider
    r = edgeNo + 19;
    t = r + 40;
    rstnQA.push_back(r);
    rstnQB.push_back(r);
    pushFreeRun(r, t + 1);
    applyStimulus(1'b1, keyV, 1'b0);
    gotoEdge(r - 1);
    checkOutput("rstn before release", {rstnA, rstnB}, 2'b00);
    gotoEdge(r);
    checkOutput("rstn at release", {rstnA, rstnB}, 2'b11);

    // Single-step mode driven by three clean presses of key 0
    gotoEdge(t);
    applyStimulus(1'b1, keyV, 1'b1);
    gotoEdge(t + 1);
    checkOutput("step not yet active", {stepA, stepB}, 2'b00);
    gotoEdge(t + 2);
    checkOutput("step active", {stepA, stepB}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      k = edgeNo;
      ceQA.push_back(k + LAT);
      ceQB.push_back(k + LAT);
      pushPress(k + LAT, 4'b0001);
      keyV[0] = 1'b0;
      applyStimulus(1'b1, keyV, 1'b1);
      gotoEdge(k + DBLAT);
      checkOutput("step key level", {dbA, dbB}, 8'h11);
      gotoEdge(k + LAT + 10);
      keyV[0] = 1'b1;
      applyStimulus(1'b1, keyV, 1'b1);
      gotoEdge(edgeNo + 20);
    end

    // Back to free-run, with key 2 pressed during the run
    f = edgeNo;
    m = f + 40;
    pushFreeRun(f + 3, m);
    applyStimulus(1'b1, keyV, 1'b0);
    gotoEdge(f + 2);
    checkOutput("step inactive", {stepA, stepB}, 2'b00);
    gotoEdge(f + 10);
    pushPress(f + 10 + LAT, 4'b0100);
    keyV[2] = 1'b0;
    applyStimulus(1'b1, keyV, 1'b0);

    // One-cycle reset pulse in the middle of the run
    gotoEdge(m);
    r2  = m + 20;
    fin = r2 + 200;
    rstnQA.push_back(r2);
    rstnQB.push_back(r2);
    pushPress(m + 1 + LAT, 4'b0100);
    pushFreeRun(r2, fin);
    applyStimulus(1'b0, keyV, 1'b0);
    #1;
    checkOutput("mid reset A", {rstnA, ceA, dbA}, '0);
    checkOutput("mid reset B", {rstnB, ceB, dbB}, '0);
    gotoEdge(m + 1);
    applyStimulus(1'b1, keyV, 1'b0);
    gotoEdge(r2 + 5);
    keyV = 4'hF;
    applyStimulus(1'b1, keyV, 1'b0);

    // All four keys pressed in the same cycle
    gotoEdge(r2 + 40);
    k = edgeNo;
    pushPress(k + LAT, 4'b1111);
    keyV = 4'h0;
    applyStimulus(1'b1, keyV, 1'b0);
    gotoEdge(k + DBLAT - 1);
    checkOutput("all keys level early", {dbA, dbB}, 8'h00);
    gotoEdge(k + DBLAT);
    checkOutput("all keys level", {dbA, dbB}, 8'hFF);
    gotoEdge(k + 30);
    keyV = 4'hF;
    applyStimulus(1'b1, keyV, 1'b0);
    gotoEdge(k + 50);

    // Key 1 bouncing on press and on release
    for (int i = 0; i < 10; i++) begin
      s = edgeNo;
      if (segLevel[i] == 0 && segDur[i] >= DBN) pushPress(s + LAT, 4'b0010);
      keyV[1] = segLevel[i][0];
      applyStimulus(1'b1, keyV, 1'b0);
      gotoEdge(s + segDur[i]);
    end

    gotoEdge(fin);
    checkOutput("ceA left", 64'(ceQA.size()), 0);
    checkOutput("ceB left", 64'(ceQB.size()), 0);
    checkOutput("rstnA left", 64'(rstnQA.size()), 0);
    checkOutput("rstnB left", 64'(rstnQB.size()), 0);
    checkOutput("pressA left", 64'(pressQA.size()), 0);
    checkOutput("pressB left", 64'(pressQB.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_RATIO, default 2, meaning CLOCK_50 cycles per core clock-enable pulse (legal range 1..65535).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning reset-deassert synchronizer depth (legal range 2..4).
REQ-003 The block SHALL have parameter POR_CYCLES, default 16, meaning extra hold cycles after synchronized deassert (legal range 0..65535).
REQ-004 The block SHALL have parameter NUM_KEYS, default 4, meaning raw key count.
REQ-005 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the stable-level count needed to accept a key change (10 ms at 50 MHz).
REQ-006 The block SHALL have parameter STEP_KEY, default 0, meaning the key index that advances single-step mode.
REQ-007 The block SHALL have port CLOCK_50, input, 1 bit: system clock; all logic on its rising edge.
REQ-008 The block SHALL have port rstn_async, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port i_key, input, NUM_KEYS bits: raw board keys, active-low, asynchronous.
REQ-010 The block SHALL have port i_step_mode, input, 1 bit: 1 = single-step, 0 = free-run; asynchronous (switch).
REQ-011 The block SHALL have port o_rstn, output, 1 bit: synchronous active-low core reset.
REQ-012 The block SHALL have port o_ce, output, 1 bit: core clock enable, one CLOCK_50 cycle wide.
REQ-013 The block SHALL have port o_key_db, output, NUM_KEYS bits: debounced key level, pressed = 1.
REQ-014 The block SHALL have port o_key_press, output, NUM_KEYS bits: one-cycle pulse on each debounced press.
REQ-015 The block SHALL have port o_step_active, output, 1 bit: synchronized i_step_mode.

Function
REQ-016 The state machine SHALL have states RST_HOLD, POR_WAIT and RUN.
- RST_HOLD -> POR_WAIT when the last sync stage reads 1.
- POR_WAIT -> RUN when the POR counter reaches POR_CYCLES; with POR_CYCLES = 0 it goes directly to RUN.
REQ-017 o_rstn SHALL be 1 only in RUN; it is registered.
REQ-018 o_rstn SHALL rise exactly SYNC_STAGES+POR_CYCLES+1 CLOCK_50 edges after the first edge that samples rstn_async high.
REQ-019 The divider counter SHALL operate as follows:
- width 16 bits;
- counts 0..DIV_RATIO-1 in RUN with free-run mode, then wraps to 0;
- o_ce = 1 in the cycle the counter equals DIV_RATIO-1;
- DIV_RATIO = 1 gives o_ce constantly 1 in RUN.
REQ-020 The divider counter SHALL be held at 0 and o_ce SHALL be 0 in RST_HOLD and POR_WAIT.
REQ-021 In step mode, o_ce SHALL equal o_key_press[STEP_KEY]; the divider is ignored and held at 0.
REQ-022 A change of o_step_active SHALL reset the divider to 0 and force o_ce = 0 in that cycle; no partial or double pulse is allowed.
REQ-023 i_step_mode and each i_key bit SHALL pass a 2-flop synchronizer; key bits are then inverted so that pressed = 1.
REQ-024 o_key_press[k] SHALL pulse for exactly one cycle, on the cycle after o_key_db[k] goes 0->1; releases produce no pulse.
REQ-025 Simultaneous presses on several keys SHALL produce independent pulses in the same cycle.
REQ-026 Reset asserted mid-operation SHALL return the block to RST_HOLD asynchronously and restart the full release sequence.

Reset
REQ-027 While rstn_async = 0, outputs SHALL be: o_rstn = 0, o_ce = 0, o_key_db = 0, o_key_press = 0, o_step_active = 0.
REQ-028 While rstn_async = 0, all counters and synchronizers SHALL be cleared.
REQ-029 Reset assertion SHALL be asynchronous; deassertion SHALL be synchronized only through SYNC_STAGES flops.

Configuration
REQ-030 Macro CLKRST_DEBOUNCE_EN SHALL control key debouncing.
- Defined: a per-key counter counts consecutive cycles in which the synced level differs from o_key_db. Reaching DEBOUNCE_CYCLES-1 updates o_key_db and clears the counter. Any cycle where they match clears the counter.
- Undefined: o_key_db equals the synced, inverted key directly (2-cycle latency); DEBOUNCE_CYCLES is unused and no counters are synthesized.

Structure
REQ-031 Package clkrst_pkg SHALL hold the state enum (RST_HOLD, POR_WAIT, RUN) and the default parameter constants.
REQ-032 Per-key logic SHALL be the sub-module key_debounce (synchronizer, debounce counter, edge pulse), instantiated NUM_KEYS times with a generate loop.

Verification
REQ-033 Reset release: with SYNC_STAGES = 2 and POR_CYCLES = 16, release rstn_async -> o_rstn rises on edge 19; o_ce stays 0 before that.
REQ-034 Divider: with DIV_RATIO = 2, free-run -> o_ce is 1 every second cycle after o_rstn rises. With DIV_RATIO = 5 -> o_ce is 1 every fifth cycle, exactly 1 cycle wide.
REQ-035 Debounce: with CLKRST_DEBOUNCE_EN and DEBOUNCE_CYCLES = 8, key 1 bounces 3 cycles low / 2 high, then holds low for 20 cycles -> exactly one o_key_press[1] pulse, and no pulse on release bounce.
REQ-036 Step mode: i_step_mode = 1 with 3 clean presses of key 0 -> exactly 3 o_ce pulses. Switching back to free-run -> the first o_ce appears DIV_RATIO cycles after o_step_active falls.
REQ-037 Mid-run reset: a 1-cycle rstn_async low pulse while o_ce is toggling -> o_rstn, o_ce and o_key_db drop immediately, and the full 19-cycle release repeats.
REQ-038 Simultaneous events: all 4 keys pressed in the same cycle -> o_key_press = 4'b1111 for one cycle; without CLKRST_DEBOUNCE_EN, o_key_db follows i_key inverted 2 cycles later.
